slc3_mem_ctrl: RTL
==================

// Module: slc3_mem_ctrl
// PURPOSE
//  Memory/IO access controller sitting between the SLC-3 datapath (MAR, MDR, MDR_In) and on-board memory.
//  Accepts read/write requests from the control FSM and runs fixed wait-state memory cycles.
//  Returns read data on MDR_In with a one-cycle ready pulse R.
//  Also decodes the memory-mapped IO word: reads return switches, writes load the hex-display register.
// PARAMETERS
//  WAIT_CYCLES  2         memory access length in Clk cycles (legal range 1..15)
//  IO_ADDR      16'hFFFF  memory-mapped IO address (switch read / hex-display write)
// PORTS
//  Clk        in   1   system clock; all state updates on posedge
//  Reset      in   1   synchronous, active-high reset
//  MEM_RD     in   1   read request (level); held by FSM until R seen
//  MEM_WR     in   1   write request (level); held by FSM until R seen
//  MAR        in   16  access address
//  MDR        in   16  write data
//  SW         in   16  switch inputs, read at IO_ADDR
//  mem_rdata  in   16  memory read data, valid during last ACCESS cycle
//  MDR_In     out  16  registered read data to datapath MDR mux
//  R          out  1   ready: high exactly one cycle per completed access
//  BUSY       out  1   high in ACCESS and DONE
//  mem_ce     out  1   memory chip enable (registered)
//  mem_we     out  1   memory write enable (registered; only with mem_ce)
//  mem_addr   out  16  memory address (registered)
//  mem_wdata  out  16  memory write data (registered)
//  HEX_DATA   out  16  hex-display register, loaded by writes to IO_ADDR
// BEHAVIOUR
//  Reset (sync, any state): state=IDLE, cnt=0. Outputs MDR_In, HEX_DATA, mem_addr, mem_wdata = 16'h0000.
//  Reset also clears R, BUSY, mem_ce and mem_we to 0. An access in flight is abandoned, with no R pulse.
//  States: IDLE, ACCESS, DONE, RELEASE.
//  IDLE: edge N samples MEM_RD|MEM_WR. Both high at once -> write wins.
//   Memory address, write: mem_addr<=MAR, mem_wdata<=MDR, mem_ce<=1, mem_we<=1, cnt<=WAIT_CYCLES-1 -> ACCESS.
//   Memory address, read: mem_addr<=MAR, mem_ce<=1, mem_we<=0, cnt<=WAIT_CYCLES-1 -> ACCESS.
//   MAR==IO_ADDR, read: MDR_In<=SW -> DONE. No memory cycle.
//   MAR==IO_ADDR, write: HEX_DATA<=MDR -> DONE. No memory cycle.
//  ACCESS: mem_ce/mem_we/mem_addr/mem_wdata held stable; lasts exactly WAIT_CYCLES cycles.
//   cnt!=0 -> cnt<=cnt-1.
//   cnt==0 -> if read, MDR_In<=mem_rdata; mem_ce<=0, mem_we<=0 -> DONE.
//  DONE: R=1 for this single cycle. Next state is RELEASE if MEM_RD|MEM_WR is still high, else IDLE.
//  RELEASE: R=0; waits until MEM_RD and MEM_WR are both low, then -> IDLE.
//   This prevents a held request from executing twice.
//  Timing:
//   Memory access: R high in the cycle after edge N+WAIT_CYCLES.
//   IO access: R high in the cycle after edge N.
//  MDR_In holds its value until the next completed read; writes never change MDR_In.
//  Memory writes never change HEX_DATA.
//  MAR, MDR and SW changes after edge N are ignored for that access.
//  R and BUSY are decoded from state. All other outputs are registered.
// STRUCTURE
//  Package slc3_mem_pkg:
//   state enum {IDLE, ACCESS, DONE, RELEASE};
//   IO_ADDR default constant;
//   cnt width constant (4 bits).
//  Sub-module slc3_wait_counter: load/decrement/zero-flag down-counter for ACCESS timing.
//  FSM, IO decode and output registers live in slc3_mem_ctrl.
// TESTING
//  1. Reset: hold Reset 2 cycles in a random state.
//     -> all outputs 0, state IDLE, then idle with no mem_ce.
//  2. Read: MAR=16'h3000, model returns 16'hBEEF, WAIT_CYCLES=2.
//     -> mem_ce=1, mem_we=0, mem_addr=16'h3000 for 2 cycles; 1-cycle R; MDR_In=16'hBEEF.
//  3. Write: MAR=16'h0040, MDR=16'h1234.
//     -> mem_we=1, mem_wdata=16'h1234 for 2 cycles; R pulse; MDR_In and HEX_DATA unchanged.
//  4. IO read: MAR=16'hFFFF, SW=16'h00A5.
//     -> no mem_ce, R after 1 edge, MDR_In=16'h00A5.
//  5. IO write: MDR=16'h0C0D.
//     -> HEX_DATA=16'h0C0D.
//  6. Held request: MEM_RD high for 10 cycles.
//     -> exactly one access and one R pulse.
//     Drop MEM_RD, re-raise -> second access.
//     MEM_RD&MEM_WR together -> write performed.
//  7. Reset mid-ACCESS (cycle 1 of 2).
//     -> next edge mem_ce=0, R never pulses; a following read at 16'h3000 completes normally.

Source files
------------

// File: rtl/slc3_mem_pkg.sv
// Shared types and constants for the SLC-3 memory/IO access controller.
package slc3_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE,
    RELEASE
  } state_t;

  localparam logic [15:0] IO_ADDR_DEFAULT = 16'hFFFF;
  localparam int unsigned CNT_W           = 4;

endpackage

// File: rtl/slc3_wait_counter.sv
// Load/decrement down-counter that times the ACCESS phase; zero flags the final cycle.
module slc3_wait_counter
  import slc3_mem_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/slc3_mem_ctrl.sv
// SLC-3 memory/IO access controller: fixed wait-state memory cycles, switch/hex IO word,
// and a one-cycle ready pulse per completed access.
module slc3_mem_ctrl
  import slc3_mem_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [15:0] IO_ADDR     = IO_ADDR_DEFAULT
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        MEM_RD,
  input  logic        MEM_WR,
  input  logic [15:0] MAR,
  input  logic [15:0] MDR,
  input  logic [15:0] SW,
  input  logic [15:0] mem_rdata,
  output logic [15:0] MDR_In,
  output logic        R,
  output logic        BUSY,
  output logic        mem_ce,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic [15:0] HEX_DATA
);

  state_t state, state_nxt;
  logic   req, is_io, start_mem, cnt_zero;

  assign req       = MEM_RD | MEM_WR;
  assign is_io     = (MAR == IO_ADDR);
  assign start_mem = (state == IDLE) && req && !is_io;

  slc3_wait_counter u_wait_counter (
    .clk      (Clk),
    .rst      (Reset),
    .load     (start_mem),
    .load_val (CNT_W'(WAIT_CYCLES - 1)),
    .dec      (state == ACCESS),
    .zero     (cnt_zero)
  );

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = is_io ? DONE : ACCESS;
      ACCESS:  if (cnt_zero) state_nxt = DONE;
      DONE:    state_nxt = req ? RELEASE : IDLE;
      RELEASE: if (!req) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    R    = 1'b0;
    BUSY = 1'b0;
    case (state)
      ACCESS:  BUSY = 1'b1;
      DONE: begin
        R    = 1'b1;
        BUSY = 1'b1;
      end
      default: ;
    endcase
  end

  // mem_we doubles as the read/write flag for the access in flight; write wins on a tie.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      MDR_In    <= '0;
      HEX_DATA  <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_ce    <= 1'b0;
      mem_we    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            if (is_io) begin
              if (MEM_WR) HEX_DATA <= MDR;
              else        MDR_In   <= SW;
            end else begin
              mem_addr <= MAR;
              mem_ce   <= 1'b1;
              mem_we   <= MEM_WR;
              if (MEM_WR) mem_wdata <= MDR;
            end
          end
        end
        ACCESS: begin
          if (cnt_zero) begin
            if (!mem_we) MDR_In <= mem_rdata;
            mem_ce <= 1'b0;
            mem_we <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
